// File: rtl/stdp_pkg.sv
// stdp_array shared types and helpers.
// Optional update counters: define STDP_UPDATE_CNT_EN.
package stdp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  localparam int DELTA_W = 17;
  typedef logic signed [DELTA_W-1:0] delta_t;

  function automatic int stdp_mag(
    input int dt,
    input int shift,
    input int window
  );
    if (dt < 0 || dt > window) return 0;
    return (window + 1 - dt) << shift;
  endfunction

  function automatic int sat_clamp(
    input int v,
    input int lo,
    input int hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/stdp_if.sv
// Weight memory port of the STDP engine.
// master = learning engine, slave = weight RAM.
interface stdp_if #(
  parameter int NUM_PRE     = 8,
  parameter int WEIGHT_SIZE = 16
);
  logic                       w_rd_en;
  logic [$clog2(NUM_PRE)-1:0] w_addr;
  logic [WEIGHT_SIZE-1:0]     w_rd_data;
  logic                       w_wr_en;
  logic [WEIGHT_SIZE-1:0]     w_wr_data;

  modport master (
    output w_rd_en, w_addr, w_wr_en, w_wr_data,
    input  w_rd_data
  );

  modport slave (
    input  w_rd_en, w_addr, w_wr_en, w_wr_data,
    output w_rd_data
  );
endinterface

// File: rtl/stdp_trace.sv
// Per-channel pre-spike trace and pending weight delta.
// Optional update counters live in the top: STDP_UPDATE_CNT_EN.
module stdp_trace
  import stdp_pkg::*;
#(
  parameter int WEIGHT_SIZE = 16,
  parameter int TS_WIDTH    = 8,
  parameter int WINDOW      = 15,
  parameter int LTP_SHIFT   = 2,
  parameter int LTD_SHIFT   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TS_WIDTH-1:0]        time_step,
  input  logic                       spk_pre,
  input  logic                       spk_post,
  input  logic                       post_vld,
  input  logic [TS_WIDTH-1:0]        t_post,
  input  logic                       take,
  output logic                       pend,
  output logic signed [WEIGHT_SIZE:0] delta
);
  localparam int DW = WEIGHT_SIZE + 1;

  logic [TS_WIDTH-1:0] t_pre;
  logic [TS_WIDTH-1:0] dt_pre;
  logic [TS_WIDTH-1:0] dt_post;
  logic                pre_vld;
  logic                ev_vld;
  int                  ltp_mag;
  int                  ltd_mag;
  int                  ev;
  int                  sum;

  always_comb begin
    dt_pre  = spk_pre ? '0 : time_step - t_pre;
    dt_post = time_step - t_post;
    ltp_mag = stdp_mag(int'(dt_pre), LTP_SHIFT, WINDOW);
    ltd_mag = (dt_post == '0) ? 0 :
              stdp_mag(int'(dt_post), LTD_SHIFT, WINDOW);
    ev      = 0;
    ev_vld  = 1'b0;
    // A same-cycle post spike wins: the pair is LTP only
    if (spk_post) begin
      if ((spk_pre || pre_vld) && ltp_mag != 0) begin
        ev     = ltp_mag;
        ev_vld = 1'b1;
      end
    end else if (spk_pre && post_vld && ltd_mag != 0) begin
      ev     = -ltd_mag;
      ev_vld = 1'b1;
    end
    sum = sat_clamp(int'(delta) + ev,
                    -(2 ** WEIGHT_SIZE),
                    (2 ** WEIGHT_SIZE) - 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_pre   <= '0;
      pre_vld <= 1'b0;
      pend    <= 1'b0;
      delta   <= '0;
    end else begin
      if (spk_pre) begin
        t_pre   <= time_step;
        pre_vld <= 1'b1;
      end
      if (take) begin
        pend  <= ev_vld;
        delta <= ev_vld ? DW'(ev) : '0;
      end else if (ev_vld) begin
        pend  <= 1'b1;
        delta <= pend ? DW'(sum) : DW'(ev);
      end
    end
  end

endmodule

// File: rtl/stdp_array.sv
// Multi-synapse STDP engine with weight read-modify-write.
// Optional ltp_cnt/ltd_cnt outputs: define STDP_UPDATE_CNT_EN.
module stdp_array
  import stdp_pkg::*;
#(
  parameter int NUM_PRE     = 8,
  parameter int WEIGHT_SIZE = 16,
  parameter int TS_WIDTH    = 8,
  parameter int WINDOW      = 15,
  parameter int LTP_SHIFT   = 2,
  parameter int LTD_SHIFT   = 1,
  parameter int W_MAX       = 1000,
  parameter int W_MIN       = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TS_WIDTH-1:0] time_step,
  input  logic [NUM_PRE-1:0]  spk_pre,
  input  logic                spk_post,
  output logic                busy,
  output logic                upd_done,
  stdp_if.master              w
`ifdef STDP_UPDATE_CNT_EN
  ,
  output logic [15:0]         ltp_cnt,
  output logic [15:0]         ltd_cnt
`endif
);
  localparam int AW = $clog2(NUM_PRE);

  state_t                     state_q, state_d;
  logic [AW-1:0]              idx_q, idx_d, low_idx;
  logic [NUM_PRE-1:0]         pend, take;
  logic signed [WEIGHT_SIZE:0] delta [NUM_PRE];
  logic signed [WEIGHT_SIZE:0] work_q;
  logic [TS_WIDTH-1:0]        t_post;
  logic                       post_vld;
  logic                       any_pend;
  logic                       rd_en, wr_en;
  logic [AW-1:0]              addr;
  logic [WEIGHT_SIZE-1:0]     wr_data;
  int                         w_sum;

  for (genvar g = 0; g < NUM_PRE; g++) begin : g_ch
    stdp_trace #(
      .WEIGHT_SIZE(WEIGHT_SIZE),
      .TS_WIDTH   (TS_WIDTH),
      .WINDOW     (WINDOW),
      .LTP_SHIFT  (LTP_SHIFT),
      .LTD_SHIFT  (LTD_SHIFT)
    ) u_trace (
      .clk      (clk),
      .rst_n    (rst_n),
      .time_step(time_step),
      .spk_pre  (spk_pre[g]),
      .spk_post (spk_post),
      .post_vld (post_vld),
      .t_post   (t_post),
      .take     (take[g]),
      .pend     (pend[g]),
      .delta    (delta[g])
    );
  end

  always_comb begin
    any_pend = |pend;
    low_idx  = '0;
    for (int i = NUM_PRE - 1; i >= 0; i--) begin
      if (pend[i]) low_idx = AW'(i);
    end
    w_sum = sat_clamp(int'({1'b0, w.w_rd_data}) + int'(work_q),
                      W_MIN, W_MAX);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    take     = '0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    addr     = '0;
    wr_data  = '0;
    upd_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_pend) begin
          state_d = RD;
          idx_d   = low_idx;
        end
      end
      RD: begin
        rd_en       = 1'b1;
        addr        = idx_q;
        take[idx_q] = 1'b1;
        state_d     = WR;
      end
      WR: begin
        wr_en    = 1'b1;
        addr     = idx_q;
        wr_data  = WEIGHT_SIZE'(w_sum);
        upd_done = 1'b1;
        state_d  = any_pend ? RD : IDLE;
        idx_d    = any_pend ? low_idx : idx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      work_q   <= '0;
      t_post   <= '0;
      post_vld <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == RD) work_q <= delta[idx_q];
      if (spk_post) begin
        t_post   <= time_step;
        post_vld <= 1'b1;
      end
    end
  end

`ifdef STDP_UPDATE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ltp_cnt <= '0;
      ltd_cnt <= '0;
    end else if (state_q == WR) begin
      if (work_q > 0 && ltp_cnt != 16'hFFFF) ltp_cnt <= ltp_cnt + 16'd1;
      if (work_q < 0 && ltd_cnt != 16'hFFFF) ltd_cnt <= ltd_cnt + 16'd1;
    end
  end
`endif

  assign busy        = any_pend | (state_q != IDLE);
  assign w.w_rd_en   = rd_en;
  assign w.w_wr_en   = wr_en;
  assign w.w_addr    = addr;
  assign w.w_wr_data = wr_data;

endmodule

// File: tb/tb_stdp_array.sv
// Directed self-checking bench for stdp_array.
// Uses a behavioural weight RAM with registered read.
module tb_stdp_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  time_step = '0;
  logic [7:0]  spk_pre = '0;
  logic        spk_post = 1'b0;
  logic        busy;
  logic        upd_done;
`ifdef STDP_UPDATE_CNT_EN
  logic [15:0] ltp_cnt;
  logic [15:0] ltd_cnt;
`endif

  stdp_if #(.NUM_PRE(8), .WEIGHT_SIZE(16)) w_if ();

  stdp_array dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .time_step(time_step),
    .spk_pre  (spk_pre),
    .spk_post (spk_post),
    .busy     (busy),
    .upd_done (upd_done),
    .w        (w_if)
`ifdef STDP_UPDATE_CNT_EN
    ,
    .ltp_cnt  (ltp_cnt),
    .ltd_cnt  (ltd_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] ram [8];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int upd_cnt = 0;
  int act_cnt = 0;
  int log_addr [4];
  int log_data [4];

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (w_if.w_wr_en) ram[w_if.w_addr] <= w_if.w_wr_data;
    if (w_if.w_rd_en) w_if.w_rd_data <= ram[w_if.w_addr];
    if (w_if.w_rd_en) rd_cnt++;
    if (w_if.w_rd_en || w_if.w_wr_en) act_cnt++;
    if (upd_done) upd_cnt++;
    if (w_if.w_wr_en) begin
      if (wr_cnt < 4) begin
        log_addr[wr_cnt] = int'(w_if.w_addr);
        log_data[wr_cnt] = int'(w_if.w_wr_data);
      end
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rd_cnt = 0;
    wr_cnt = 0;
    upd_cnt = 0;
    act_cnt = 0;
  endtask

  task automatic preload(input int a, input int d);
    pl_en = 1'b1;
    pl_addr = 3'(a);
    pl_data = 16'(d);
    tick();
    pl_en = 1'b0;
  endtask

  task automatic spike(input int ts, input int pre, input bit post);
    time_step = 8'(ts);
    spk_pre = 8'(pre);
    spk_post = post;
    tick();
    spk_pre = '0;
    spk_post = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    if (busy) chk({tag, "_timeout"}, 1, 0);
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(w_if.w_rd_en), 0);
    chk("rst_wr_en", int'(w_if.w_wr_en), 0);
    chk("rst_upd", int'(upd_done), 0);

    // LTP with cycle-level latency checks
    do_reset();
    preload(3, 100);
    spike(10, 8'h08, 0);
    chk("ltp_pre_only_busy", int'(busy), 0);
    spike(14, 0, 1);
    chk("ltp_e0_busy", int'(busy), 1);
    chk("ltp_e0_rd", int'(w_if.w_rd_en), 0);
    tick();
    chk("ltp_e1_rd", int'(w_if.w_rd_en), 1);
    chk("ltp_e1_addr", int'(w_if.w_addr), 3);
    tick();
    chk("ltp_e2_wr", int'(w_if.w_wr_en), 1);
    chk("ltp_e2_addr", int'(w_if.w_addr), 3);
    chk("ltp_e2_data", int'(w_if.w_wr_data), 148);
    chk("ltp_e2_upd", int'(upd_done), 1);
    tick();
    chk("ltp_idle_busy", int'(busy), 0);
    chk("ltp_rd_cnt", rd_cnt, 1);
    chk("ltp_wr_cnt", wr_cnt, 1);
    chk("ltp_upd_cnt", upd_cnt, 1);
    chk("ltp_ram", int'(ram[3]), 148);

    // LTD
    do_reset();
    preload(5, 100);
    spike(20, 0, 1);
    spike(23, 8'h20, 0);
    wait_idle("ltd");
    chk("ltd_wr_cnt", wr_cnt, 1);
    chk("ltd_addr", log_addr[0], 5);
    chk("ltd_data", log_data[0], 74);

    // Window edge: dt=16 ignored, dt=15 gives +4
    do_reset();
    spike(40, 8'h01, 0);
    spike(56, 0, 1);
    chk("win16_busy", int'(busy), 0);
    tick();
    tick();
    chk("win16_rd_cnt", rd_cnt, 0);
    chk("win16_wr_cnt", wr_cnt, 0);
    do_reset();
    preload(0, 100);
    spike(40, 8'h01, 0);
    spike(55, 0, 1);
    wait_idle("win15");
    chk("win15_wr_cnt", wr_cnt, 1);
    chk("win15_data", log_data[0], 104);

    // Clamps
    do_reset();
    preload(3, 990);
    spike(10, 8'h08, 0);
    spike(14, 0, 1);
    wait_idle("cmax");
    chk("clamp_max", log_data[0], 1000);
    do_reset();
    preload(5, 10);
    spike(20, 0, 1);
    spike(23, 8'h20, 0);
    wait_idle("cmin");
    chk("clamp_min", log_data[0], 0);

    // Simultaneous pre/post on two channels, with an earlier post trace
    do_reset();
    preload(0, 100);
    preload(7, 100);
    spike(28, 0, 1);
    chk("sim_post_only_busy", int'(busy), 0);
    spike(30, 8'h81, 1);
    wait_idle("sim");
    chk("sim_wr_cnt", wr_cnt, 2);
    chk("sim_addr0", log_addr[0], 0);
    chk("sim_data0", log_data[0], 164);
    chk("sim_addr1", log_addr[1], 7);
    chk("sim_data1", log_data[1], 164);
    chk("sim_active", act_cnt, 4);

    // Reset while in RD, before WR
    do_reset();
    preload(3, 100);
    spike(10, 8'h08, 0);
    spike(14, 0, 1);
    tick();
    chk("rmid_rd", int'(w_if.w_rd_en), 1);
    rst_n = 1'b0;
    tick();
    chk("rmid_wr_en", int'(w_if.w_wr_en), 0);
    chk("rmid_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();
    spike(16, 0, 1);
    tick();
    tick();
    chk("rmid_wr_cnt", wr_cnt, 0);
    chk("rmid_busy_after", int'(busy), 0);
    chk("rmid_ram", int'(ram[3]), 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
